upsampler_v_sequencer: RTL and testbench

- Front-end controller for the vertical 2x upsampler convolution (1-wide x 5-tall FP kernel).
- Accepts a raster stream of low-resolution FP pixels and conceptually inserts zero rows: upsampled row 2k = input row k, row 2k+1 = all zeros.
- Builds the 5-tall zero-padded vertical window for every upsampled pixel and issues windows in raster order, with col/row tags, to the convolution datapath.
- Owns three line buffers and the input-stall schedule. The datapath has no backpressure.

---
 rtl/upsampler_v_sequencer_if.sv | 24 ++
 rtl/upsampler_v_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_upsampler_v_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/upsampler_v_sequencer_if.sv
// rtl/upsampler_v_sequencer_if.sv - pixel input stream and window output bundle
// master = pixel source / window sink, slave = sequencer.
interface upsampler_v_sequencer_if #(
  parameter int FP_WIDTH_REG = 16
);
  logic [FP_WIDTH_REG-1:0]             data_i;
  logic                                valid_i;
  logic                                ready_o;
  logic [0:4][0:0][FP_WIDTH_REG-1:0]   window_o;
  logic [15:0]                         col_o;
  logic [15:0]                         row_o;
  logic                                valid_o;
  logic                                frame_done_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, window_o, col_o, row_o, valid_o, frame_done_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, window_o, col_o, row_o, valid_o, frame_done_o
  );
endinterface

// File: rtl/upsampler_v_sequencer.sv
// rtl/upsampler_v_sequencer.sv - vertical 2x upsampler window sequencer
// Buffers input rows in three rotating line buffers and emits 5-tall zero-stuffed windows.
module upsampler_v_sequencer #(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  upsampler_v_sequencer_if.slave   bus
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [15:0] COL_LAST      = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] K_LAST        = 16'(IMG_HEIGHT - 2);
  localparam logic [15:0] ROW_TAIL_EVEN = 16'(2 * IMG_HEIGHT - 2);
  localparam logic [15:0] ROW_TAIL_ODD  = 16'(2 * IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_STREAM,
    S_FLUSH_ODD,
    S_TAIL_EVEN,
    S_TAIL_ODD
  } state_t;

  typedef logic [0:4][0:0][FP_WIDTH_REG-1:0] window_t;

  state_t      state_q, state_d;
  logic [15:0] col_q, col_d;
  logic [15:0] k_q, k_d;
  // Buffer slots holding input rows k-1, k and k+1; rotated instead of computing k mod 3.
  logic [1:0]  prev_q, prev_d;
  logic [1:0]  cur_q, cur_d;
  logic [1:0]  next_q, next_d;
  logic        ready_q, ready_d;

  window_t     win_q, win_d;
  logic [15:0] col_out_q, col_out_d;
  logic [15:0] row_q, row_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic                     wr_en;
  logic [1:0]               wr_slot;
  logic [AW-1:0]            col_idx;
  logic                     accept;
  logic                     last_col;
  logic [FP_WIDTH_REG-1:0]  rd_prev, rd_cur, rd_next;

  logic [FP_WIDTH_REG-1:0]  line_buf [3][IMG_WIDTH];

  assign col_idx  = col_q[AW-1:0];
  assign accept   = bus.valid_i && ready_q;
  assign last_col = (col_q == COL_LAST);

  assign rd_prev = line_buf[prev_q][col_idx];
  assign rd_cur  = line_buf[cur_q][col_idx];
  assign rd_next = line_buf[next_q][col_idx];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      line_buf[wr_slot][col_idx] <= bus.data_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    k_d       = k_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    next_d    = next_q;
    wr_en     = 1'b0;
    wr_slot   = cur_q;
    win_d     = '0;
    col_out_d = '0;
    row_d     = '0;
    valid_d   = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_slot = cur_q;
          if (last_col) begin
            col_d   = '0;
            state_d = S_STREAM;
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end

      S_STREAM: begin
        if (accept) begin
          wr_en        = 1'b1;
          wr_slot      = next_q;
          valid_d      = 1'b1;
          col_out_d    = col_q;
          row_d        = {k_q[14:0], 1'b0};
          win_d[0][0]  = (k_q == 16'd0) ? '0 : rd_prev;
          win_d[2][0]  = rd_cur;
          // Row k+1 is still being written, so take it straight from the input.
          win_d[4][0]  = bus.data_i;
          if (last_col) begin
            col_d   = '0;
            state_d = S_FLUSH_ODD;
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end

      S_FLUSH_ODD: begin
        valid_d     = 1'b1;
        col_out_d   = col_q;
        row_d       = {k_q[14:0], 1'b1};
        win_d[1][0] = rd_cur;
        win_d[3][0] = rd_next;
        if (last_col) begin
          col_d = '0;
          if (k_q == K_LAST) begin
            state_d = S_TAIL_EVEN;
          end else begin
            k_d     = k_q + 16'd1;
            prev_d  = cur_q;
            cur_d   = next_q;
            next_d  = prev_q;
            state_d = S_STREAM;
          end
        end else begin
          col_d = col_q + 16'd1;
        end
      end

      S_TAIL_EVEN: begin
        valid_d     = 1'b1;
        col_out_d   = col_q;
        row_d       = ROW_TAIL_EVEN;
        win_d[0][0] = rd_cur;
        win_d[2][0] = rd_next;
        if (last_col) begin
          col_d   = '0;
          state_d = S_TAIL_ODD;
        end else begin
          col_d = col_q + 16'd1;
        end
      end

      S_TAIL_ODD: begin
        valid_d     = 1'b1;
        col_out_d   = col_q;
        row_d       = ROW_TAIL_ODD;
        win_d[1][0] = rd_next;
        if (last_col) begin
          done_d  = 1'b1;
          col_d   = '0;
          k_d     = '0;
          prev_d  = 2'd2;
          cur_d   = 2'd0;
          next_d  = 2'd1;
          state_d = S_FILL;
        end else begin
          col_d = col_q + 16'd1;
        end
      end

      default: begin
        state_d = S_FILL;
        col_d   = '0;
        k_d     = '0;
        prev_d  = 2'd2;
        cur_d   = 2'd0;
        next_d  = 2'd1;
      end
    endcase

    ready_d = (state_d == S_FILL) || (state_d == S_STREAM);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FILL;
      col_q     <= '0;
      k_q       <= '0;
      prev_q    <= 2'd2;
      cur_q     <= 2'd0;
      next_q    <= 2'd1;
      ready_q   <= 1'b0;
      win_q     <= '0;
      col_out_q <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      k_q       <= k_d;
      prev_q    <= prev_d;
      cur_q     <= cur_d;
      next_q    <= next_d;
      ready_q   <= ready_d;
      win_q     <= win_d;
      col_out_q <= col_out_d;
      row_q     <= row_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready_o      = ready_q;
  assign bus.window_o     = win_q;
  assign bus.col_o        = col_out_q;
  assign bus.row_o        = row_q;
  assign bus.valid_o      = valid_q;
  assign bus.frame_done_o = done_q;

endmodule

// File: tb/tb_upsampler_v_sequencer.sv
// tb/tb_upsampler_v_sequencer.sv - self-checking bench for upsampler_v_sequencer
// Expected windows come from sampling the conceptually zero-stuffed image at rows r-2..r+2.
module tb_upsampler_v_sequencer;
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int FPW = 16;

  typedef logic [0:4][0:0][FPW-1:0] window_t;
  typedef struct {
    window_t     win;
    logic [15:0] col;
    logic [15:0] row;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  upsampler_v_sequencer_if #(.FP_WIDTH_REG(FPW)) bus ();

  upsampler_v_sequencer #(
    .EXP_WIDTH(5), .FRAC_WIDTH(10), .FP_WIDTH_REG(FPW),
    .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int          vectors    = 0;
  int          miscompares = 0;
  int          stall_cnt  = 0;
  int          done_cnt   = 0;
  bit          chk_en     = 1'b1;
  exp_t        exp_q[$];
  logic [15:0] in_q[$];
  logic [15:0] px [H][W];

  function automatic logic [15:0] up_px(int u, int c);
    if (u < 0 || u >= 2 * H || (u % 2) != 0) return 16'h0000;
    return px[u / 2][c];
  endfunction

  task automatic gen_frame();
    exp_t e;
    for (int r = 0; r < 2 * H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int j = 0; j < 5; j++) e.win[j][0] = up_px(r - 2 + j, c);
        e.col  = 16'(c);
        e.row  = 16'(r);
        e.done = (r == 2 * H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < H; k++)
      for (int c = 0; c < W; c++) in_q.push_back(px[k][c]);
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (!bus.ready_o) stall_cnt++;
    if (bus.frame_done_o) done_cnt++;
    if (chk_en && bus.valid_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL extra_window observed row=%0d col=%0d expected none", bus.row_o, bus.col_o);
      end else begin
        e = exp_q.pop_front();
        check("window", bus.window_o, e.win);
        check("col", bus.col_o, e.col);
        check("row", bus.row_o, e.row);
        check("frame_done", bus.frame_done_o, e.done);
      end
    end else if (chk_en) begin
      check("done_idle", bus.frame_done_o, 1'b0);
    end
  endtask

  // mode 0: valid held high, 1: toggling 1/0, 2: random
  task automatic run(input int mode);
    int budget;
    bit v;
    bit phase;
    bit acc;
    budget = 4000;
    phase  = 1'b1;
    while (in_q.size() > 0 && budget > 0) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? phase : 1'($urandom_range(0, 1));
      phase = ~phase;
      bus.valid_i = v;
      bus.data_i  = in_q[0];
      acc = v && bus.ready_o;
      cycle();
      if (acc) void'(in_q.pop_front());
      budget--;
    end
    bus.valid_i = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    check("drain_left", 80'(exp_q.size() + in_q.size()), 80'd0);
    exp_q.delete();
    in_q.delete();
  endtask

  initial begin
    int acc_n;
    int b;
    bit acc;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;

    rst = 1'b1;
    cycle();
    cycle();
    check("rst_valid", bus.valid_o, 1'b0);
    check("rst_done", bus.frame_done_o, 1'b0);
    check("rst_window", bus.window_o, '0);
    check("rst_ready", bus.ready_o, 1'b0);
    rst = 1'b0;
    cycle();
    check("ready_after_rst", bus.ready_o, 1'b1);

    // Constant rows, valid held high
    for (int c = 0; c < W; c++) begin
      px[0][c] = 16'h3C00; px[1][c] = 16'h4000; px[2][c] = 16'h4200;
    end
    gen_frame();
    stall_cnt = 0; done_cnt = 0;
    run(0);
    check("stall_held", 80'(stall_cnt), 80'((H + 1) * W));
    check("done_held", 80'(done_cnt), 80'd1);

    // Same frame with valid toggling
    gen_frame();
    stall_cnt = 0; done_cnt = 0;
    run(1);
    check("stall_toggle", 80'(stall_cnt), 80'((H + 1) * W));
    check("done_toggle", 80'(done_cnt), 80'd1);

    // Per-column distinct data
    for (int k = 0; k < H; k++)
      for (int c = 0; c < W; c++) px[k][c] = 16'h3C00 + 16'(c) + 16'(k * 16);
    gen_frame();
    run(0);

    // Reset mid-STREAM at input row 1 col 2
    chk_en = 1'b0;
    acc_n  = 0;
    b      = 100;
    while (acc_n < W + 2 && b > 0) begin
      bus.valid_i = 1'b1;
      bus.data_i  = 16'($urandom);
      acc = bus.ready_o;
      cycle();
      if (acc) acc_n++;
      b--;
    end
    check("mid_pre_valid", bus.valid_o, 1'b1);
    rst = 1'b1;
    cycle();
    check("mid_rst_valid", bus.valid_o, 1'b0);
    check("mid_rst_window", bus.window_o, '0);
    rst = 1'b0;
    bus.valid_i = 1'b0;
    cycle();
    check("mid_ready", bus.ready_o, 1'b1);
    chk_en = 1'b1;
    for (int k = 0; k < H; k++)
      for (int c = 0; c < W; c++) px[k][c] = 16'($urandom);
    gen_frame();
    done_cnt = 0;
    run(0);
    check("done_after_rst", 80'(done_cnt), 80'd1);

    // Two frames back-to-back
    for (int c = 0; c < W; c++) begin
      px[0][c] = 16'h4400; px[1][c] = 16'h4500; px[2][c] = 16'h4600;
    end
    gen_frame();
    for (int c = 0; c < W; c++) begin
      px[0][c] = 16'hC000; px[1][c] = 16'hC200; px[2][c] = 16'hC400;
    end
    gen_frame();
    stall_cnt = 0; done_cnt = 0;
    run(0);
    check("b2b_done", 80'(done_cnt), 80'd2);
    check("b2b_stall", 80'(stall_cnt), 80'(2 * (H + 1) * W));

    // Random data with random valid, twice
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < H; k++)
        for (int c = 0; c < W; c++) px[k][c] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      gen_frame();
      done_cnt = 0;
      run(2);
      check("rand_done", 80'(done_cnt), 80'd1);
    end

    for (int i = 0; i < 4; i++) cycle();
    check("idle_valid", bus.valid_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
